// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one iterative multiplier among NUM_REQ requesters.
// Round-robin grant in IDLE, then CLEAR -> SETTLE -> RUN -> RESP sequencing of the
// multiplier, and a one-cycle ack with the product back to the winner.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a stuck RUN after
// TIMEOUT_CYCLES cycles with err=1 and result=0.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       mult_reset_n,
  output logic                       mult_ready,
  output logic [WIDTH-1:0]           mult_in1,
  output logic [WIDTH-1:0]           mult_in2,
  input  logic                       mult_done,
  input  logic [WIDTH-1:0]           mult_out
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  // Reject configurations the arbiter was not built for at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mult_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    RUN,
    RESP
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cand_idx;
  logic [IDW-1:0]     pick_idx;
  logic               pick_valid;
  logic [WIDTH-1:0]   pick_in1;
  logic [WIDTH-1:0]   pick_in2;
  logic [NUM_REQ-1:0] grant_oh;

  logic               take_grant;
  logic               capture;
  logic               timeout_hit;
  logic               wd_expired;

  // Round-robin search: first set req bit starting just above the last winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Operand mux selecting the candidate winner's flattened operand slices.
  always_comb begin
    pick_in1 = '0;
    pick_in2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_in1 = req_in1[i*WIDTH +: WIDTH];
        pick_in2 = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot decode of the latched grant, used for the ack pulse.
  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (grant_id == IDW'(i));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_next  = state;
    take_grant  = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = CLEAR;
          take_grant = 1'b1;
        end
      end
      CLEAR:  state_next = SETTLE;
      SETTLE: state_next = RUN;
      RUN: begin
        if (mult_done) begin
          state_next = RESP;
          capture    = 1'b1;
        end else if (wd_expired) begin
          state_next  = RESP;
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so each one lines up
  // exactly with the state it belongs to while still having its own reset value
  // (mult_reset_n is low in reset even though IDLE drives it high).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy         <= 1'b0;
      mult_reset_n <= 1'b0;
      mult_ready   <= 1'b0;
      ack          <= '0;
    end else begin
      busy         <= (state_next != IDLE);
      mult_reset_n <= (state_next != CLEAR);
      mult_ready   <= (state_next == RUN);
      ack          <= (state_next == RESP) ? grant_oh : '0;
    end
  end

  // Grant bookkeeping and operand latch, updated only on an IDLE grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      mult_in1 <= '0;
      mult_in2 <= '0;
    end else if (take_grant) begin
      rr_ptr   <= pick_idx;
      grant_id <= pick_idx;
      mult_in1 <= pick_in1;
      mult_in2 <= pick_in2;
    end
  end

  // Result register: product on completion, zero on a watchdog abort, else held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
    end else if (capture) begin
      result <= mult_out;
    end else if (timeout_hit) begin
      result <= '0;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: held at zero outside RUN, so it restarts on every RUN entry.
  always_ff @(posedge clk) begin
    if (!reset_n || state != RUN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // err accompanies the ack of an aborted transaction only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= timeout_hit;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: behavioural iterative multiplier, directed
// stimulus, and a scoreboard queue checked by an independent ack monitor.
module tb_mult_share_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned IDW = 2;
  localparam int unsigned LAT = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   req_in1;
  logic [NR*W-1:0]   req_in2;
  logic [NR-1:0]     ack;
  logic [W-1:0]      result;
  logic              err;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              mult_reset_n;
  logic              mult_ready;
  logic [W-1:0]      mult_in1;
  logic [W-1:0]      mult_in2;
  logic              mult_done;
  logic [W-1:0]      mult_out;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ(NR),
    .WIDTH(W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_in1(req_in1),
    .req_in2(req_in2),
    .ack(ack),
    .result(result),
    .err(err),
    .busy(busy),
    .grant_id(grant_id),
    .mult_reset_n(mult_reset_n),
    .mult_ready(mult_ready),
    .mult_in1(mult_in1),
    .mult_in2(mult_in2),
    .mult_done(mult_done),
    .mult_out(mult_out)
  );

  // Multiplier model: accumulates into acc (only reset clears it), done is sticky.
  logic [W-1:0] acc;
  logic         done;
  int unsigned  mcnt;
  logic         stuck;

  always @(posedge clk) begin
    if (!mult_reset_n) begin
      acc  <= '0;
      done <= 1'b0;
      mcnt <= 0;
    end else if (mult_ready && !done && !stuck) begin
      if (mcnt == LAT - 1) begin
        acc  <= acc + mult_in1 * mult_in2;
        done <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  assign mult_done = done;
  assign mult_out  = acc;

  typedef struct packed {
    logic [NR-1:0]  ack;
    logic [W-1:0]   res;
    logic           err;
    logic [IDW-1:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input int unsigned i, input logic [W-1:0] r, input logic e);
    exp_t x;
    x.ack = NR'(1) << i;
    x.res = r;
    x.err = e;
    x.gid = IDW'(i);
    exp_q.push_back(x);
  endtask

  // Ack monitor: every ack must match the oldest expectation and last one cycle.
  logic [NR-1:0] prev_ack = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && ack != '0) begin
      if (prev_ack != '0) check("ack_single_cycle", 64'(prev_ack), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_onehot", 64'(ack), 64'(e.ack));
        check("result", 64'(result), 64'(e.res));
        check("err", 64'(err), 64'(e.err));
        check("grant_id", 64'(grant_id), 64'(e.gid));
      end
    end
    prev_ack <= reset_n ? ack : '0;
  end

  task automatic put(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
    req[i]            = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_mult_reset_n"}, 64'(mult_reset_n), 64'd0);
    check({tag, "_mult_ready"}, 64'(mult_ready), 64'd0);
    check({tag, "_mult_in1"}, 64'(mult_in1), 64'd0);
    check({tag, "_mult_in2"}, 64'(mult_in2), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Serve all pending requests: drop each req bit on its ack, stop once idle.
  task automatic drain(input int unsigned budget);
    int unsigned c = 0;
    while ((req != '0 || busy || ack != '0) && c < budget) begin
      @(negedge clk);
      c++;
      req = req & ~ack;
    end
    if (req != '0 || busy) check("drain_timeout", 64'({req, busy}), 64'd0);
  endtask

  task automatic wait_ack(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 64);
    if (ack == '0) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_wait: no ack within %0d cycles", n);
    end
  endtask

  task automatic wait_ready(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mult_ready && n < 32);
    if (!mult_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_wait: mult_ready not seen within %0d cycles", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned n;
    reset_n = 1'b0;
    req     = '0;
    req_in1 = '0;
    req_in2 = '0;
    stuck   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_mult_reset_n", 64'(mult_reset_n), 64'd1);

    // Single request 3x4: CLEAR, SETTLE, RUN, then ack 5 cycles into RUN.
    put(0, 3, 4);
    expect_txn(0, 12, 1'b0);
    @(negedge clk);
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_mult_reset_n", 64'(mult_reset_n), 64'd0);
    check("clear_mult_ready", 64'(mult_ready), 64'd0);
    check("clear_in1", 64'(mult_in1), 64'd3);
    check("clear_in2", 64'(mult_in2), 64'd4);
    @(negedge clk);
    check("settle_mult_reset_n", 64'(mult_reset_n), 64'd1);
    check("settle_mult_ready", 64'(mult_ready), 64'd0);
    @(negedge clk);
    check("run_mult_ready", 64'(mult_ready), 64'd1);
    wait_ack(n);
    check("done_to_ack_latency", 64'(n), 64'd5);
    req = '0;
    @(negedge clk);
    check("post_ack_busy", 64'(busy), 64'd0);
    check("post_ack_ack", 64'(ack), 64'd0);
    check("result_persists", 64'(result), 64'd12);

    // Contention from reset: grants 0,1,2,3.
    do_reset();
    put(0, 2, 5);
    put(1, 3, 5);
    put(2, 4, 5);
    put(3, 6, 5);
    expect_txn(0, 10, 1'b0);
    expect_txn(1, 15, 1'b0);
    expect_txn(2, 20, 1'b0);
    expect_txn(3, 30, 1'b0);
    drain(200);

    // Round-robin resume: after req1, req0 and req3 together -> 3 then 0.
    put(1, 11, 3);
    expect_txn(1, 33, 1'b0);
    drain(60);
    put(0, 10, 10);
    put(3, 12, 12);
    expect_txn(3, 144, 1'b0);
    expect_txn(0, 100, 1'b0);
    drain(120);

    // Back-to-back req2 7x6: second result must be 42 again.
    put(2, 7, 6);
    expect_txn(2, 42, 1'b0);
    expect_txn(2, 42, 1'b0);
    wait_ack(n);
    wait_ack(n);
    req = '0;
    @(negedge clk);
    check("b2b_busy", 64'(busy), 64'd0);

    // Reset during RUN: everything back to reset values, no ack for req3.
    put(3, 8, 8);
    wait_ready(n);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    check_reset_vals("midrun");
    reset_n = 1'b1;
    put(0, 9, 9);
    expect_txn(0, 81, 1'b0);
    drain(60);

    // Multiplier never completes.
    stuck = 1'b1;
    put(1, 5, 5);
    wait_ready(n);
`ifdef MULT_ARB_TIMEOUT_EN
    expect_txn(1, 0, 1'b1);
    wait_ack(n);
    check("timeout_latency", 64'(n), 64'd16);
    req   = '0;
    stuck = 1'b0;
    drain(20);
`else
    repeat (40) @(negedge clk);
    check("stuck_busy", 64'(busy), 64'd1);
    check("stuck_mult_ready", 64'(mult_ready), 64'd1);
    stuck = 1'b0;
    do_reset();
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
